// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    LOAD = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam int IMEM_DEPTH     = 256;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;

endpackage

// File: rtl/imem_loader_packer.sv
// Big-endian byte-to-word packer: the first byte of each group of four ends up in bits [31:24].
module byte_packer
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        in_data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [1:0]  cnt;
  logic [23:0] shift;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt   <= '0;
      shift <= '0;
    end else if (accept) begin
      cnt   <= cnt + 2'd1;
      shift <= {shift[15:0], in_data};
    end
  end

  // The word completes combinationally on the 4th byte so the owner can register it that same edge.
  assign word_valid = accept && (cnt == 2'(BYTES_PER_WORD - 1));
  assign word       = {shift, in_data};

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed byte image into instruction memory, one word write per 4 payload bytes.
//   state | meaning
//   IDLE  | after reset, waiting for start
//   HDR   | collecting the 4-byte big-endian word count N
//   LOAD  | collecting payload, one memory write per completed word
//   DONE  | last load finished (done=1)
//   ERR   | header N exceeded DEPTH, nothing written (err=1)
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int CNT_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  words_loaded
);

  state_t              state;
  logic [CNT_W-1:0]    len;
  logic                accept;
  logic                pk_clear;
  logic                word_valid;
  logic [WORD_W-1:0]   word;
  logic [CNT_W-1:0]    wl_next;

  assign in_ready = (state == HDR) || (state == LOAD);
  assign accept   = in_valid && in_ready;
  assign pk_clear = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign wl_next  = words_loaded + CNT_W'(1);

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pk_clear),
    .accept     (accept),
    .in_data    (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      len          <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= HDR;
            busy         <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
          end
        end
        HDR: begin
          if (word_valid) begin
            if (word == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (word > WORD_W'(DEPTH)) begin
              state <= ERR;
              busy  <= 1'b0;
              err   <= 1'b1;
            end else begin
              state <= LOAD;
              len   <= word[CNT_W-1:0];
            end
          end
        end
        LOAD: begin
          if (word_valid) begin
            mem_we       <= 1'b1;
            mem_wdata    <= word;
            mem_addr     <= {{(32-CNT_W-2){1'b0}}, words_loaded, 2'b00};
            words_loaded <= wl_next;
            if (wl_next == len) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random streams against a word-list reference model.
module tb_imem_loader;

  localparam int DEPTH = 256;
  localparam int CNT_W = 9;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_ready;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] words_loaded;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        dn;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] exp_q[$];
  logic [7:0]  stream[$];

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always @(negedge clk) begin
    if (mem_we === 1'b1) wq.push_back('{addr: mem_addr, data: mem_wdata, dn: done});
  end

  // Reference: header gives N; valid N yields N big-endian words written at 4*i.
  function automatic void model(input logic [7:0] b[$]);
    logic [31:0] n;
    logic [31:0] w;
    exp_q.delete();
    n = {b[0], b[1], b[2], b[3]};
    if (n == 0 || n > DEPTH) return;
    for (int i = 0; i < int'(n); i++) begin
      w = 0;
      for (int k = 0; k < 4; k++) w = (w << 8) | 32'(b[4 + 4*i + k]);
      exp_q.push_back(w);
    end
  endfunction

  function automatic void build(input int n, input logic [31:0] hdr);
    stream.delete();
    stream.push_back(hdr[31:24]);
    stream.push_back(hdr[23:16]);
    stream.push_back(hdr[15:8]);
    stream.push_back(hdr[7:0]);
    for (int i = 0; i < 4*n; i++) stream.push_back(8'($urandom));
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offers stream bytes; gaps randomly drops in_valid, start_at pulses start alongside byte index start_at.
  task automatic drive(input int gaps, input int start_at, output int cycles);
    int  i;
    logic acc;
    i = 0;
    cycles = 0;
    while (i < stream.size() && cycles < 20000) begin
      in_valid = (gaps == 0) || ($urandom_range(0, 2) != 0);
      in_data  = in_valid ? stream[i] : 8'($urandom);
      start    = (i == start_at);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      cycles++;
      if (acc) i++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    total++;
    if (i != stream.size()) begin
      bad++;
      $display("FAIL drive_timeout: accepted=%0d need=%0d", i, stream.size());
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL wait_idle: busy stuck at %b", busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, words_loaded} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b we=%b addr=%h data=%h busy=%b done=%b err=%b wl=%0d, want all 0",
               in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, words_loaded);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int cyc;
    logic [7:0] fixed[16] = '{8'h00, 8'h00, 8'h00, 8'h03, 8'h8C, 8'h01, 8'h00, 8'h07,
                              8'h20, 8'h21, 8'h00, 8'h01, 8'hAC, 8'h01, 8'h00, 8'h02};
    logic [31:0] want[3] = '{32'h8C010007, 32'h20210001, 32'hAC010002};
    stream.delete();
    foreach (fixed[i]) stream.push_back(fixed[i]);
    wq.delete();
    pulse_start();
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_busy: busy=%b rdy=%b want 1 1", busy, in_ready);
    end
    drive(0, -1, cyc);
    wait_idle();
    total++;
    if (cyc != 16) begin
      bad++;
      $display("FAIL basic_throughput: cycles=%0d want 16", cyc);
    end
    total++;
    if (wq.size() != 3) begin
      bad++;
      $display("FAIL basic_count: writes=%0d want 3", wq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (wq[i].addr !== 32'(4*i) || wq[i].data !== want[i] || wq[i].dn !== (i == 2)) begin
          bad++;
          $display("FAIL basic_write%0d: addr=%h data=%h done=%b want %h %h %b",
                   i, wq[i].addr, wq[i].data, wq[i].dn, 32'(4*i), want[i], i == 2);
        end
      end
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || words_loaded !== 9'd3 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_final: done=%b busy=%b wl=%0d rdy=%b want 1 0 3 0", done, busy, words_loaded, in_ready);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    int n;
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 12);
      build(n, 32'(n));
      model(stream);
      wq.delete();
      pulse_start();
      drive(1, -1, cyc);
      wait_idle();
      total++;
      if (wq.size() != exp_q.size()) begin
        bad++;
        $display("FAIL bp_count%0d: writes=%0d want %0d", r, wq.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          total++;
          if (wq[i].addr !== 32'(4*i) || wq[i].data !== exp_q[i]) begin
            bad++;
            $display("FAIL bp_write%0d_%0d: addr=%h data=%h want %h %h", r, i, wq[i].addr, wq[i].data, 32'(4*i), exp_q[i]);
          end
        end
      end
      total++;
      if (done !== 1'b1 || words_loaded !== CNT_W'(n)) begin
        bad++;
        $display("FAIL bp_final%0d: done=%b wl=%0d want 1 %0d", r, done, words_loaded, n);
      end
      // Bytes offered while idle in DONE must not be consumed or change state.
      in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || words_loaded !== CNT_W'(n) || mem_we !== 1'b0) begin
        bad++;
        $display("FAIL bp_idle_valid%0d: done=%b busy=%b wl=%0d we=%b", r, done, busy, words_loaded, mem_we);
      end
    end
  endtask

  task automatic test_bounds();
    int cyc;
    build(DEPTH, 32'(DEPTH));
    model(stream);
    wq.delete();
    pulse_start();
    drive(0, -1, cyc);
    wait_idle();
    total++;
    if (wq.size() != DEPTH) begin
      bad++;
      $display("FAIL max_count: writes=%0d want %0d", wq.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        total++;
        if (wq[i].addr !== 32'(4*i) || wq[i].data !== exp_q[i]) begin
          bad++;
          $display("FAIL max_write%0d: addr=%h data=%h want %h %h", i, wq[i].addr, wq[i].data, 32'(4*i), exp_q[i]);
        end
      end
      total++;
      if (wq[DEPTH-1].addr !== 32'h3FC) begin
        bad++;
        $display("FAIL max_last_addr: got %h want 000003fc", wq[DEPTH-1].addr);
      end
    end
    total++;
    if (done !== 1'b1 || err !== 1'b0 || words_loaded !== 9'd256) begin
      bad++;
      $display("FAIL max_final: done=%b err=%b wl=%0d want 1 0 256", done, err, words_loaded);
    end

    build(0, 32'(DEPTH + 1));
    wq.delete();
    pulse_start();
    drive(0, -1, cyc);
    wait_idle();
    total++;
    if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || wq.size() != 0) begin
      bad++;
      $display("FAIL over_len: err=%b done=%b busy=%b rdy=%b writes=%0d want 1 0 0 0 0",
               err, done, busy, in_ready, wq.size());
    end

    build(0, 32'h0);
    wq.delete();
    pulse_start();
    total++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL restart_from_err: err=%b busy=%b want 0 1", err, busy);
    end
    drive(0, -1, cyc);
    wait_idle();
    total++;
    if (done !== 1'b1 || words_loaded !== 9'd0 || wq.size() != 0 || err !== 1'b0) begin
      bad++;
      $display("FAIL zero_len: done=%b wl=%0d writes=%0d err=%b want 1 0 0 0", done, words_loaded, wq.size(), err);
    end
  endtask

  task automatic test_reset_midload();
    int cyc;
    build(3, 32'd3);
    while (stream.size() > 10) void'(stream.pop_back());
    pulse_start();
    drive(0, -1, cyc);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, words_loaded} !== '0) begin
      bad++;
      $display("FAIL midload_reset: rdy=%b we=%b addr=%h data=%h busy=%b done=%b err=%b wl=%0d want all 0",
               in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, words_loaded);
    end
    build(1, 32'd1);
    model(stream);
    wq.delete();
    @(posedge clk); #1;
    pulse_start();
    drive(0, -1, cyc);
    wait_idle();
    total++;
    if (wq.size() != 1 || wq[0].addr !== 32'h0 || wq[0].data !== exp_q[0] || words_loaded !== 9'd1) begin
      bad++;
      $display("FAIL midload_reload: writes=%0d addr=%h data=%h wl=%0d want 1 0 %h 1",
               wq.size(), (wq.size() > 0) ? wq[0].addr : 32'hx, (wq.size() > 0) ? wq[0].data : 32'hx,
               words_loaded, exp_q[0]);
    end
  endtask

  task automatic test_restart();
    int cyc;
    build(2, 32'd2);
    model(stream);
    wq.delete();
    pulse_start();
    drive(0, 6, cyc);
    wait_idle();
    total++;
    if (wq.size() != 2) begin
      bad++;
      $display("FAIL ignored_start_count: writes=%0d want 2", wq.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (wq[i].addr !== 32'(4*i) || wq[i].data !== exp_q[i]) begin
          bad++;
          $display("FAIL ignored_start_write%0d: addr=%h data=%h want %h %h", i, wq[i].addr, wq[i].data, 32'(4*i), exp_q[i]);
        end
      end
    end
    total++;
    if (done !== 1'b1 || words_loaded !== 9'd2) begin
      bad++;
      $display("FAIL ignored_start_final: done=%b wl=%0d want 1 2", done, words_loaded);
    end
    stream.delete();
    stream = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    wq.delete();
    pulse_start();
    total++;
    if (done !== 1'b0 || words_loaded !== 9'd0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL restart_entry: done=%b wl=%0d busy=%b want 0 0 1", done, words_loaded, busy);
    end
    drive(0, -1, cyc);
    wait_idle();
    total++;
    if (wq.size() != 1 || wq[0].addr !== 32'h0 || wq[0].data !== 32'hDEADBEEF || words_loaded !== 9'd1) begin
      bad++;
      $display("FAIL restart_write: writes=%0d addr=%h data=%h wl=%0d want 1 0 deadbeef 1",
               wq.size(), (wq.size() > 0) ? wq[0].addr : 32'hx, (wq.size() > 0) ? wq[0].data : 32'hx, words_loaded);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_bounds();
    test_reset_midload();
    test_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the instruction memory: receives a byte stream over a valid/ready handshake and packs it into big-endian 32-bit words.
- Issues one write per word to the instruction memory write port, at consecutive word-aligned byte addresses starting at 0.
- Holds the CPU stalled while loading and reports done or error.
- Sits between the external boot or debug byte source and the instruction memory.

Parameters:
- DEPTH, 256, instruction memory size in 32-bit words; maximum accepted program length.
- CNT_W, 9, width of word counters; must satisfy 2**CNT_W > DEPTH.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- in_valid  input  1  byte source has a byte on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  one-cycle write strobe to instruction memory.
- mem_addr  output  32  byte address of the write; always word-aligned, bits [1:0] = 0.
- mem_wdata  output  32  instruction word to write.
- busy  output  1  load in progress; drives the CPU stall/hold.
- done  output  1  level; last load completed successfully.
- err  output  1  level; header length exceeded DEPTH.
- words_loaded  output  CNT_W  words written in the current or last load.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all outputs 0; byte counter, shift register and length register cleared.
- Reset mid-load aborts the load. A partially assembled word is discarded. Words already written to memory are not undone.
- Handshake: a byte transfers when in_valid && in_ready. in_ready is combinational from state only: 1 in HDR and LOAD, else 0.
- Byte order: big-endian; the first byte of a group lands in bits [31:24].
- A 2-bit byte counter wraps 3->0 on each 4th accepted byte.
- State IDLE: start -> HDR; busy=1; words_loaded=0.
- State HDR: accept 4 bytes forming length N.
  - N==0 -> DONE.
  - N>DEPTH -> ERR.
  - Otherwise -> LOAD.
- State LOAD: on each 4th accepted byte, the next cycle drives:
  - mem_we=1 for exactly 1 cycle;
  - mem_wdata = {shift[23:0], byte};
  - mem_addr = words_loaded<<2 (the pre-increment value);
  - words_loaded incremented.
- Throughput: 1 byte/cycle sustained. mem_wdata and mem_addr are registered separately from the shift register, so a write cycle never stalls intake.
- LOAD -> DONE on acceptance of the final byte of word N. The last mem_we pulse coincides with the first DONE cycle.
- State DONE: done=1, busy=0, in_ready=0.
- State ERR: err=1, busy=0, in_ready=0; no memory writes have occurred.
- DONE/ERR + start -> HDR. On entry, done and err clear, words_loaded=0 and the byte counter is cleared.
- start while in HDR or LOAD is ignored.
- in_valid while in_ready=0: byte not consumed; no state change.
- mem_we is never asserted outside LOAD or the first DONE cycle.
- Address arithmetic: 32-bit, zero-extended from words_loaded. The maximum address is (DEPTH-1)*4; no wrap is possible because the length is checked in HDR.

Decomposition:
- Package imem_pkg:
  - state enum: IDLE, HDR, LOAD, DONE, ERR;
  - IMEM_DEPTH = 256;
  - BYTES_PER_WORD = 4;
  - WORD_W = 32.
- Sub-module byte_packer: 2-bit counter plus 24-bit shift register; outputs word_valid and word. Reused for both the header and payload words.
- The top-level FSM, counters and write-port registers live in imem_loader.

Test Plan:
- Basic program: start, then bytes 00 00 00 03 | 8C 01 00 07 | 20 21 00 01 | AC 01 00 02 at 1 byte/cycle -> three mem_we pulses:
  - addr 0x0, data 0x8C010007;
  - addr 0x4, data 0x20210001;
  - addr 0x8, data 0xAC010002;
  - then done=1, busy=0, words_loaded=3.
- Backpressure/gaps: same stream with in_valid toggled randomly -> identical writes and order; no byte lost or duplicated.
- Length bounds:
  - header 00 00 01 00 (256) -> accepted; last write at addr 0x3FC;
  - header 00 00 01 01 -> ERR, err=1, mem_we never asserted;
  - header 00 00 00 00 -> DONE immediately, words_loaded=0.
- Reset mid-load: reset asserted after 6 payload bytes -> next cycle all outputs 0, state IDLE. A new start followed by a 1-word load writes addr 0x0.
- Restart and ignored start: start pulsed during LOAD -> no effect. After DONE, a second start with a 1-word stream (data 0xDEADBEEF) -> writes addr 0x0 and words_loaded=1.
